// File: rtl/ece571f23_g5_aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Round keys come from an external, already-expanded key store addressed by rk_idx,
// which is read combinationally in the same cycle (rk_in).
module ece571f23_g5_aes_inv_cipher #(
   parameter int NR       = 10,
   parameter int RK_IDX_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        data_in,
   output logic [RK_IDX_W-1:0] rk_idx,
   input  logic [127:0]        rk_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        data_out,
   output logic                busy
);

   if (NR != 10) begin : g_bad_nr
      $fatal(1, "ece571f23_g5_aes_inv_cipher supports only NR=10 (AES-128)");
   end

   localparam logic [RK_IDX_W-1:0] NR_IDX  = RK_IDX_W'(NR);
   localparam logic [RK_IDX_W-1:0] ONE_IDX = RK_IDX_W'(1);

   // FIPS-197 inverse S-box; entry k sits at bits [2047-8k -: 8]
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

   state_t              state, next_state;
   logic [RK_IDX_W-1:0] rnd;
   logic [127:0]        st;
   logic [127:0]        dout;
   logic [127:0]        sub_shift;
   logic [127:0]        final_out;
   logic [127:0]        round_out;

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Row r of the state is rotated right by r columns
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int k = 0; k < 16; k++) begin
         o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
      end
      return o;
   endfunction

   // Multiples 9, b, d, e built from the x2/x4/x8 xtime chain of each byte
   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a, x2, x4, x8;
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [31:0] o;
      o = '0;
      for (int i = 0; i < 4; i++) begin
         a     = c[31-8*i -: 8];
         x2    = xtime(a);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a;
         mb[i] = x8 ^ x2 ^ a;
         md[i] = x8 ^ x4 ^ a;
         me[i] = x8 ^ x4 ^ x2;
      end
      for (int r = 0; r < 4; r++) begin
         o[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
      end
      return o;
   endfunction

   assign sub_shift = inv_sub_bytes(inv_shift_rows(st));
   assign final_out = sub_shift ^ rk_in;
   assign round_out = inv_mix_columns(final_out);
   assign data_out  = dout;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state, handshakes and key-store address, all from registered state/rnd
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      rk_idx     = NR_IDX;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) next_state = ROUND;
         end
         ROUND: begin
            rk_idx = rnd;
            if (rnd == ONE_IDX) next_state = FINAL;
         end
         FINAL: begin
            rk_idx     = '0;
            next_state = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Cipher state, round counter and the output register (loaded only by the final round)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st   <= '0;
         rnd  <= NR_IDX;
         dout <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  st  <= data_in ^ rk_in;
                  rnd <= NR_IDX - ONE_IDX;
               end
            end
            ROUND: begin
               st  <= round_out;
               rnd <= rnd - ONE_IDX;
            end
            FINAL: begin
               st   <= final_out;
               dout <= final_out;
            end
            DONE: begin
               if (out_ready) rnd <= NR_IDX;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ece571f23_g5_aes_inv_cipher.sv
// Scoreboard bench for the AES-128 inverse cipher: directed FIPS-197 vectors,
// a bench-side key schedule feeding the key store, and a handshake monitor.
module tb_ece571f23_g5_aes_inv_cipher;

   localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

   // Forward S-box, used only by the key schedule
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] data_in;
   logic [3:0]   rk_idx;
   logic [127:0] rk_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] data_out;
   logic         busy;

   logic [127:0] rks1 [0:10];
   logic [127:0] rks2 [0:10];
   logic         keysel;
   logic [127:0] exp_q [$];
   int           tests;
   int           fails;
   int           cyc;

   ece571f23_g5_aes_inv_cipher #(.NR(10), .RK_IDX_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .rk_idx(rk_idx), .rk_in(rk_in), .out_valid(out_valid),
      .out_ready(out_ready), .data_out(data_out), .busy(busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Combinational key store read
   always_comb begin
      rk_in = '0;
      if (rk_idx <= 4'd10) rk_in = keysel ? rks2[rk_idx] : rks1[rk_idx];
   end

   // Handshake inputs must be known once reset is released
   always @(posedge clk) begin
      if (rst_n) assert (!$isunknown({in_valid, out_ready}))
         else $error("[TB] X on in_valid/out_ready");
   end

   function automatic void checkOutput(input string name, input logic [127:0] act,
                                       input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction

   // FIPS-197 AES-128 key expansion into one of the two key-store banks
   task automatic expandKey(input logic [127:0] key, input bit sel);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
            rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) begin
         if (sel) rks2[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         else     rks1[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
   endtask

   // Scoreboard monitor: compare on every output handshake
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected output", data_out, 128'h0);
         end else begin
            checkOutput("plaintext", data_out, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for the accepting edge; reports cycle stamp and rk_idx seen while accepting
   task automatic waitAccept(output int when, output logic [3:0] idx);
      when = -1;
      idx  = '0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready && in_valid) begin
            when = cyc;
            idx  = rk_idx;
            tick();
            return;
         end
      end
      checkOutput("accept timeout", 128'd0, 128'd1);
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready && !out_valid) return;
      end
      checkOutput("idle timeout", 128'd0, 128'd1);
   endtask

   // Issues one block; with trace set it checks every key index and the output latency
   task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] pt,
                                input bit sel, input bit trace);
      int         when;
      logic [3:0] idx;
      bit         early;
      keysel = sel;
      exp_q.push_back(pt);
      data_in  = ct;
      in_valid = 1'b1;
      waitAccept(when, idx);
      in_valid = 1'b0;
      if (trace) begin
         checkOutput("rk_idx at accept", 128'(idx), 128'd10);
         early = 1'b0;
         for (int r = 9; r >= 0; r--) begin
            @(negedge clk);
            checkOutput($sformatf("rk_idx round %0d", r), 128'(rk_idx), 128'(r));
            if (out_valid || in_ready) early = 1'b1;
            tick();
         end
         checkOutput("no early valid/ready", 128'(early), 128'd0);
         @(negedge clk);
         checkOutput("latency out_valid", 128'(out_valid), 128'd1);
         #1;
      end
   endtask

   initial begin
      int         t1;
      int         t2;
      logic [3:0] idx;
      bit         seen;
      tests = 0; fails = 0; cyc = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; data_in = '0; keysel = 1'b0;
      expandKey(KEY1, 1'b0);
      expandKey(KEY2, 1'b1);

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset in_ready", 128'(in_ready), 128'd1);
      checkOutput("reset out_valid", 128'(out_valid), 128'd0);
      checkOutput("reset data_out", data_out, 128'd0);
      checkOutput("reset busy", 128'(busy), 128'd0);
      checkOutput("reset rk_idx", 128'(rk_idx), 128'd10);
      rst_n = 1'b1;
      tick();

      // Vector 1 with full key-index trace
      applyStimulus(CT1, PT1, 1'b0, 1'b1);
      waitIdle();
      checkOutput("data_out held in idle", data_out, PT1);
      checkOutput("idle busy", 128'(busy), 128'd0);
      tick();

      // Vector 2 under 20 cycles of backpressure, with in_valid offered and ignored
      out_ready = 1'b0;
      applyStimulus(CT2, PT2, 1'b1, 1'b1);
      in_valid = 1'b1;
      data_in  = CT1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("bp out_valid", 128'(out_valid), 128'd1);
         checkOutput("bp data_out", data_out, PT2);
         checkOutput("bp in_ready", 128'(in_ready), 128'd0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      checkOutput("idle after release in_ready", 128'(in_ready), 128'd1);
      checkOutput("idle after release out_valid", 128'(out_valid), 128'd0);
      tick();

      // Reset in the middle of a block, at round index 5
      applyStimulus(CT1, PT1, 1'b0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (rk_idx == 4'd5 && busy) seen = 1'b1;
         else tick();
      end
      checkOutput("reached round 5", 128'(seen), 128'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset out_valid", 128'(out_valid), 128'd0);
      checkOutput("midreset data_out", data_out, 128'd0);
      checkOutput("midreset in_ready", 128'(in_ready), 128'd1);
      checkOutput("midreset busy", 128'(busy), 128'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      applyStimulus(CT1, PT1, 1'b0, 1'b1);
      waitIdle();
      tick();

      // Back-to-back with in_valid held high
      exp_q.push_back(PT1);
      exp_q.push_back(PT2);
      keysel   = 1'b0;
      data_in  = CT1;
      in_valid = 1'b1;
      waitAccept(t1, idx);
      data_in = CT2;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checkOutput("b2b first output seen", 128'(seen), 128'd1);
      keysel = 1'b1;
      waitAccept(t2, idx);
      in_valid = 1'b0;
      checkOutput("b2b accept spacing", 128'(t2 - t1), 128'd12);
      waitIdle();
      tick();

      checkOutput("scoreboard drained", 128'(exp_q.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule
